hazard_fwd_unit: RTL and testbench

HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

---
 rtl/hazard_fwd_unit.sv | 81 ++++++++
 tb/tb_hazard_fwd_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: operand forwarding selects, load-use stall FSM and saturating perf counters
module hazard_fwd_unit #(
  parameter int AW       = 5,
  parameter int NSRC     = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NSRC*AW-1:0]   IFID_rs,
  input  logic [NSRC-1:0]      IFID_use,
  input  logic [NSRC*AW-1:0]   IDEX_rs,
  input  logic [AW-1:0]        IDEX_rd,
  input  logic                 IDEX_MemRead,
  input  logic [AW-1:0]        EXMEM_rd,
  input  logic                 EXMEM_RegWrite,
  input  logic [AW-1:0]        MEMWB_rd,
  input  logic                 MEMWB_RegWrite,
  input  logic [AW-1:0]        WBR_rd,
  input  logic                 WBR_RegWrite,
  input  logic                 flush,
  output logic [2*NSRC-1:0]    fwd_sel,
  output logic                 stall,
  output logic                 idex_bubble,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     fwd_cnt
);
  typedef enum logic {IDLE, HOLD} state_t;
  localparam logic [2:0] BCNT_INIT = LOAD_LAT > 1 ? 3'(LOAD_LAT - 2) : 3'd0;
  state_t state, state_nxt;
  logic [2:0] bcnt, bcnt_nxt;
  logic hz, any_use;
  for (genvar s = 0; s < NSRC; s++) begin : g_src
    logic [AW-1:0] rs;
    assign rs = IDEX_rs[s*AW +: AW];
    // youngest producer wins; rd==0 is never a real destination
    assign fwd_sel[2*s +: 2] =
      (EXMEM_RegWrite && EXMEM_rd != '0 && EXMEM_rd == rs) ? 2'b10 :
      (MEMWB_RegWrite && MEMWB_rd != '0 && MEMWB_rd == rs) ? 2'b01 :
      (WBR_RegWrite   && WBR_rd   != '0 && WBR_rd   == rs) ? 2'b11 : 2'b00;
  end
  always_comb begin
    any_use = 1'b0;
    for (int i = 0; i < NSRC; i++) any_use = any_use | (IFID_use[i] && IFID_rs[i*AW +: AW] == IDEX_rd);
    hz = IDEX_MemRead && IDEX_rd != '0 && any_use;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      bcnt  <= '0;
    end else begin
      state <= state_nxt;
      bcnt  <= bcnt_nxt;
    end
  always_comb begin
    state_nxt = state;
    bcnt_nxt  = bcnt;
    if (flush) begin
      state_nxt = IDLE;
      bcnt_nxt  = '0;
    end else if (state == HOLD) begin
      state_nxt = bcnt == '0 ? IDLE : HOLD;
      bcnt_nxt  = bcnt == '0 ? bcnt : bcnt - 3'd1;
    end else if (hz && LOAD_LAT > 1) begin
      state_nxt = HOLD;
      bcnt_nxt  = BCNT_INIT;
    end
  end
  always_comb begin
    stall       = !flush && (state == HOLD || hz);
    idex_bubble = flush || state == HOLD || hz;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (|fwd_sel && fwd_cnt != '1) fwd_cnt <= fwd_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: directed and random checks against a remaining-stall-cycles reference model
module tb_hazard_fwd_unit;
  localparam int AW = 5, NSRC = 3, LL = 3, CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [NSRC*AW-1:0] ifid_rs, idex_rs;
  logic [NSRC-1:0] ifid_use;
  logic [AW-1:0] idex_rd, exmem_rd, memwb_rd, wbr_rd;
  logic idex_memread, exmem_rw, memwb_rw, wbr_rw, flush;
  logic [2*NSRC-1:0] fwd_sel;
  logic stall, idex_bubble;
  logic [CW-1:0] stall_cnt, fwd_cnt;
  int n_checks = 0, n_fail = 0;
  int left = 0, m_stall_cnt = 0, m_fwd_cnt = 0;

  hazard_fwd_unit #(.AW(AW), .NSRC(NSRC), .LOAD_LAT(LL), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .IFID_rs(ifid_rs), .IFID_use(ifid_use), .IDEX_rs(idex_rs),
    .IDEX_rd(idex_rd), .IDEX_MemRead(idex_memread), .EXMEM_rd(exmem_rd), .EXMEM_RegWrite(exmem_rw),
    .MEMWB_rd(memwb_rd), .MEMWB_RegWrite(memwb_rw), .WBR_rd(wbr_rd), .WBR_RegWrite(wbr_rw),
    .flush(flush), .fwd_sel(fwd_sel), .stall(stall), .idex_bubble(idex_bubble),
    .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] m_sel(input logic [AW-1:0] rs);
    if (exmem_rw && exmem_rd != 0 && exmem_rd == rs) return 2'b10;
    if (memwb_rw && memwb_rd != 0 && memwb_rd == rs) return 2'b01;
    if (wbr_rw && wbr_rd != 0 && wbr_rd == rs) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic m_hz();
    bit hit = 0;
    for (int i = 0; i < NSRC; i++)
      if (ifid_use[i] && ifid_rs[i*AW +: AW] == idex_rd) hit = 1;
    return idex_memread && idex_rd != 0 && hit;
  endfunction

  function automatic logic [2*NSRC-1:0] m_fwd();
    logic [2*NSRC-1:0] v;
    for (int s = 0; s < NSRC; s++) v[2*s +: 2] = m_sel(idex_rs[s*AW +: AW]);
    return v;
  endfunction

  function automatic logic m_stall();
    return !flush && (left > 0 || m_hz());
  endfunction

  task automatic check_all(input string tag);
    #1;
    check({tag, ".fwd"}, fwd_sel, m_fwd());
    check({tag, ".stall"}, stall, m_stall());
    check({tag, ".bubble"}, idex_bubble, flush || left > 0 || m_hz());
    check({tag, ".scnt"}, stall_cnt, m_stall_cnt);
    check({tag, ".fcnt"}, fwd_cnt, m_fwd_cnt);
  endtask

  task automatic tick();
    logic st, fw, h;
    st = m_stall(); fw = |m_fwd(); h = m_hz();
    @(posedge clk); #1;
    if (st && m_stall_cnt < CMAX) m_stall_cnt++;
    if (fw && m_fwd_cnt < CMAX) m_fwd_cnt++;
    if (flush) left = 0;
    else if (left > 0) left--;
    else if (h) left = LL - 1;
  endtask

  task automatic clear();
    ifid_rs = '0; idex_rs = '0; ifid_use = '0; idex_rd = '0; exmem_rd = '0; memwb_rd = '0;
    wbr_rd = '0; idex_memread = 0; exmem_rw = 0; memwb_rw = 0; wbr_rw = 0; flush = 0;
  endtask

  task automatic model_reset();
    left = 0; m_stall_cnt = 0; m_fwd_cnt = 0;
  endtask

  task automatic pulse_reset();
    rst_n = 0; model_reset(); #2; rst_n = 1;
  endtask

  task automatic load_hazard();
    idex_memread = 1; idex_rd = 4; ifid_rs[1*AW +: AW] = 4; ifid_use[1] = 1;
  endtask

  initial begin
    clear();
    check_all("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    // forwarding priority
    idex_rs[0 +: AW] = 5; exmem_rd = 5; exmem_rw = 1; memwb_rd = 5; memwb_rw = 1;
    check_all("exmem"); check("exmem.sel0", fwd_sel[1:0], 2'b10); tick();
    exmem_rd = 0;
    check_all("memwb"); check("memwb.sel0", fwd_sel[1:0], 2'b01); tick();
    memwb_rd = 0; wbr_rd = 0; wbr_rw = 1;
    check_all("rd0"); check("rd0.sel0", fwd_sel[1:0], 2'b00); tick();
    clear();
    idex_rs[2*AW +: AW] = 7; wbr_rd = 7; wbr_rw = 1;
    check_all("wbr"); check("wbr.sel2", fwd_sel[5:4], 2'b11); tick();
    check_all("wbr2"); tick();
    check_all("wbr3"); check("wbr.fcnt", fwd_cnt, 4'd4);
    // load-use stall of exactly LL cycles
    clear(); pulse_reset();
    load_hazard();
    check_all("ld1"); check("ld1.stall", stall, 1'b1); tick();
    clear();
    check_all("ld2"); check("ld2.stall", stall, 1'b1); tick();
    check_all("ld3"); check("ld3.stall", stall, 1'b1); tick();
    check_all("ld4"); check("ld4.stall", stall, 1'b0); check("ld4.scnt", stall_cnt, 4'd3); tick();
    // flush in second stall cycle
    load_hazard();
    check_all("fl1"); tick();
    clear(); flush = 1;
    check_all("fl2"); check("fl2.stall", stall, 1'b0); check("fl2.bubble", idex_bubble, 1'b1); tick();
    flush = 0;
    check_all("fl3"); check("fl3.stall", stall, 1'b0); tick();
    // async reset mid-HOLD
    load_hazard();
    check_all("ar1"); tick();
    clear(); #1;
    check("ar.hold", stall, 1'b1);
    rst_n = 0; model_reset(); #1;
    check("ar.stall", stall, 1'b0); check("ar.scnt", stall_cnt, 4'd0);
    #1 rst_n = 1;
    repeat (3) begin tick(); check_all("ar.after"); end
    // saturation under sustained stall
    pulse_reset();
    load_hazard();
    for (int c = 0; c < 20; c++) begin check_all("sat"); tick(); end
    check_all("sat.end"); check("sat.scnt", stall_cnt, 4'd15);
    // random traffic
    clear(); pulse_reset();
    for (int c = 0; c < 400; c++) begin
      for (int s = 0; s < NSRC; s++) begin
        ifid_rs[s*AW +: AW] = AW'($urandom_range(0, 3));
        idex_rs[s*AW +: AW] = AW'($urandom_range(0, 3));
      end
      ifid_use = NSRC'($urandom);
      idex_rd = AW'($urandom_range(0, 3)); idex_memread = 1'($urandom);
      exmem_rd = AW'($urandom_range(0, 3)); exmem_rw = 1'($urandom);
      memwb_rd = AW'($urandom_range(0, 3)); memwb_rw = 1'($urandom);
      wbr_rd = AW'($urandom_range(0, 3)); wbr_rw = 1'($urandom);
      flush = $urandom_range(0, 7) == 0;
      if (c % 40 == 39) pulse_reset();
      check_all("rnd"); tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
